cve2_wb_stage: RTL and testbench
================================

Name: cve2_wb_stage

Overview:
- Parametrised writeback stage for the cve2 core; successor to the unregistered writeback passthrough.
- Sits between ID/EX and the register file.
- Holds one retiring instruction in a pipeline register and merges ALU/CSR results with late LSU load data.
- Exposes a forwarding path and a ready handshake to ID, and generates retire performance pulses only when the instruction actually completes.
- With WritebackStage=0 it degenerates to a combinational passthrough.

Parameters:
- WritebackStage, 1, 1 = registered stage (one-entry buffer); 0 = combinational passthrough, no state.
- DataWidth, 32, width of RF write data.
- AddrWidth, 5, width of RF write address.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- en_wb_i  input  1  ID hands an instruction to WB this cycle
- instr_is_load_id_i  input  1  handed instruction is a load; RF data comes from LSU
- instr_is_compressed_id_i  input  1  handed instruction is compressed
- instr_perf_count_id_i  input  1  handed instruction counts toward retire counters
- rf_waddr_id_i  input  AddrWidth  destination register
- rf_wdata_id_i  input  DataWidth  ID/EX result
- rf_we_id_i  input  1  ID/EX result is written
- rf_wdata_lsu_i  input  DataWidth  load data
- rf_we_lsu_i  input  1  LSU requests RF write
- lsu_resp_valid_i  input  1  LSU response this cycle
- lsu_resp_err_i  input  1  LSU response is an error
- ready_wb_o  output  1  WB can accept en_wb_i this cycle
- outstanding_load_wb_o  output  1  WB holds a load awaiting response
- rf_waddr_wb_o  output  AddrWidth  RF write address
- rf_wdata_wb_o  output  DataWidth  RF write data
- rf_we_wb_o  output  1  RF write enable
- rf_fwd_valid_wb_o  output  1  rf_wdata_wb_o holds a forwardable non-load result
- perf_instr_ret_wb_o  output  1  one-cycle pulse per retired counted instruction
- perf_instr_ret_compressed_wb_o  output  1  retire pulse qualified by compressed

Behaviour:
- WritebackStage=1 state: valid_q, is_load_q, we_q, compressed_q, perf_q, waddr_q, wdata_q.
- Reset (rst_i=1 at posedge): valid_q=0 and all fields 0. Consequently every output is 0, except ready_wb_o=1.
- Two logical states:
  - EMPTY (valid_q=0)
  - FULL (valid_q=1); FULL with is_load_q=1 is the load-wait condition.
- Commit condition: commit = valid_q & (~is_load_q | lsu_resp_valid_i).
- ready_wb_o = ~valid_q | commit, so a new entry is accepted on the same edge the current one commits.
- Capture:
  - en_wb_i & ready_wb_o loads all fields from the *_id_i inputs and sets valid_q=1.
  - If commit occurs without capture, valid_q clears.
- Latency:
  - Non-load result handed in cycle N is written to the RF in cycle N+1.
  - Load is written in the cycle lsu_resp_valid_i is seen, earliest N+1.
- RF outputs:
  - rf_waddr_wb_o = waddr_q.
  - Non-load: rf_we_wb_o = valid_q & we_q; rf_wdata_wb_o = wdata_q.
  - Load: rf_we_wb_o = commit & rf_we_lsu_i & ~lsu_resp_err_i; rf_wdata_wb_o = rf_wdata_lsu_i.
  - When rf_we_wb_o=0, rf_wdata_wb_o is 0 (AND-masked).
- Forwarding: rf_fwd_valid_wb_o = valid_q & we_q & ~is_load_q.
- outstanding_load_wb_o = valid_q & is_load_q.
- Perf:
  - perf_instr_ret_wb_o = commit & perf_q & ~(is_load_q & lsu_resp_err_i).
  - Compressed pulse = perf_instr_ret_wb_o & compressed_q.
  - Each pulse lasts exactly one cycle per instruction.
- Load error: entry retires, no RF write, no perf pulse.
- Load entries ignore rf_we_id_i (we_q forced 0 at capture).
- Assertions (ASSERT macros):
  - en_wb_i only when ready_wb_o.
  - lsu_resp_valid_i only when outstanding_load_wb_o.
  - rf_we_lsu_i implies lsu_resp_valid_i.
  - Violations leave state unchanged (en_wb_i ignored when not ready).
- Reset mid-load: entry dropped, a later LSU response is ignored, and no write or perf pulse occurs.
- WritebackStage=0: no flops.
  - ready_wb_o=1, outstanding_load_wb_o=0, rf_fwd_valid_wb_o=0, rf_waddr_wb_o=rf_waddr_id_i.
  - rf_wdata_wb_o = OR of AND-masked ID and LSU sources; rf_we_wb_o = rf_we_id_i | rf_we_lsu_i.
  - perf_instr_ret_wb_o = en_wb_i & instr_perf_count_id_i & ~(lsu_resp_valid_i & lsu_resp_err_i).

Test Plan:
- Reset then idle -> ready_wb_o=1, all other outputs 0 for 10 cycles.
- ALU op waddr=5, wdata=0xDEADBEEF, we=1, perf=1, compressed=1 at cycle N -> at N+1: rf_we_wb_o=1, addr 5, data 0xDEADBEEF, fwd valid=1, both perf pulses=1; all 0 at N+2.
- Load to x7 with response 3 cycles later, data 0x1234 -> ready_wb_o=0 and outstanding=1 for 3 cycles, then a single-cycle write of 0x1234 to x7 with a perf pulse; an en_wb_i presented in the response cycle is accepted.
- Load with lsu_resp_err_i=1 -> rf_we_wb_o=0, no perf pulse, stage returns EMPTY next cycle.
- Back-to-back ALU ops on 4 consecutive cycles -> 4 consecutive writes, ready_wb_o held 1, exactly 4 perf pulses.
- rst_i asserted during load wait, then a stray LSU response -> no RF write, no perf pulse, ready_wb_o=1.

Source files
------------

// File: rtl/cve2_wb_stage_if.sv
// ----------------------------------------------------------------------------
// cve2_wb_stage_if
//
// Purpose:
//    Bundles every signal between ID/EX, the LSU response path, the register
//    file and the writeback stage. clk/rst stay as plain ports on the stage.
//
// Modports:
//    slave  - the writeback stage (consumes *_i, produces *_o)
//    master - the surrounding pipeline / testbench (drives *_i, observes *_o)
//
// Handshake (valid/ready):
//    en_wb_i is a valid strobe qualified by ready_wb_o. A transfer happens on
//    the rising clock edge where en_wb_i & ready_wb_o. en_wb_i must not be
//    raised while ready_wb_o is low; the stage ignores it if it is.
//    lsu_resp_valid_i is a one-cycle response strobe with no back-pressure;
//    it is only meaningful while outstanding_load_wb_o is high.
// ----------------------------------------------------------------------------
interface cve2_wb_stage_if #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 5
) ();

   // ID/EX -> WB
   logic                 en_wb_i;
   logic                 instr_is_load_id_i;
   logic                 instr_is_compressed_id_i;
   logic                 instr_perf_count_id_i;
   logic [AddrWidth-1:0] rf_waddr_id_i;
   logic [DataWidth-1:0] rf_wdata_id_i;
   logic                 rf_we_id_i;

   // LSU -> WB
   logic [DataWidth-1:0] rf_wdata_lsu_i;
   logic                 rf_we_lsu_i;
   logic                 lsu_resp_valid_i;
   logic                 lsu_resp_err_i;

   // WB -> ID / RF / perf counters
   logic                 ready_wb_o;
   logic                 outstanding_load_wb_o;
   logic [AddrWidth-1:0] rf_waddr_wb_o;
   logic [DataWidth-1:0] rf_wdata_wb_o;
   logic                 rf_we_wb_o;
   logic                 rf_fwd_valid_wb_o;
   logic                 perf_instr_ret_wb_o;
   logic                 perf_instr_ret_compressed_wb_o;

   modport slave (
      input  en_wb_i, instr_is_load_id_i, instr_is_compressed_id_i,
             instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
             rf_wdata_lsu_i, rf_we_lsu_i, lsu_resp_valid_i, lsu_resp_err_i,
      output ready_wb_o, outstanding_load_wb_o, rf_waddr_wb_o, rf_wdata_wb_o,
             rf_we_wb_o, rf_fwd_valid_wb_o, perf_instr_ret_wb_o,
             perf_instr_ret_compressed_wb_o
   );

   modport master (
      output en_wb_i, instr_is_load_id_i, instr_is_compressed_id_i,
             instr_perf_count_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
             rf_wdata_lsu_i, rf_we_lsu_i, lsu_resp_valid_i, lsu_resp_err_i,
      input  ready_wb_o, outstanding_load_wb_o, rf_waddr_wb_o, rf_wdata_wb_o,
             rf_we_wb_o, rf_fwd_valid_wb_o, perf_instr_ret_wb_o,
             perf_instr_ret_compressed_wb_o
   );

endinterface

// File: rtl/cve2_wb_stage.sv
// ----------------------------------------------------------------------------
// cve2_wb_stage
//
// Purpose:
//    Writeback stage of the cve2 core, between ID/EX and the register file.
//    With WritebackStage=1 it holds one retiring instruction and merges its
//    ALU/CSR result with late LSU load data; with WritebackStage=0 it is a
//    purely combinational passthrough.
//
// Ports:
//    clk_i  - clock
//    rst_i  - synchronous active-high reset
//    wb     - cve2_wb_stage_if.slave: ID hand-off, LSU response, RF write
//             port, forwarding/ready back to ID, retire perf pulses.
//
// State (WritebackStage=1): EMPTY / FULL. FULL with a load entry is the
// load-wait condition; the entry commits when the LSU response arrives.
// ----------------------------------------------------------------------------
module cve2_wb_stage #(
   parameter bit          WritebackStage = 1'b1,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned AddrWidth      = 5
) (
   input  logic            clk_i,
   input  logic            rst_i,
   cve2_wb_stage_if.slave  wb
);

   // Output values, driven by whichever generate branch is elaborated.
   logic                 ready_wb;
   logic                 outstanding_load_wb;
   logic [AddrWidth-1:0] rf_waddr_wb;
   logic [DataWidth-1:0] rf_wdata_wb;
   logic                 rf_we_wb;
   logic                 rf_fwd_valid_wb;
   logic                 perf_instr_ret_wb;
   logic                 perf_instr_ret_compressed_wb;

   if (WritebackStage) begin : g_registered

      typedef enum logic {
         EMPTY = 1'b0,
         FULL  = 1'b1
      } wb_state_e;

      wb_state_e            state_q, state_d;
      logic                 is_load_q, is_load_d;
      logic                 we_q, we_d;
      logic                 compressed_q, compressed_d;
      logic                 perf_q, perf_d;
      logic [AddrWidth-1:0] waddr_q, waddr_d;
      logic [DataWidth-1:0] wdata_q, wdata_d;

      logic valid_q;
      logic commit;
      logic capture;
      logic rf_we_int;

      assign valid_q = (state_q == FULL);

      // A load entry can only leave once its response shows up; anything
      // else leaves on the cycle after it was captured.
      assign commit  = valid_q & (~is_load_q | wb.lsu_resp_valid_i);
      assign ready_wb = ~valid_q | commit;
      assign capture  = wb.en_wb_i & ready_wb;

      always_comb begin
         state_d      = state_q;
         is_load_d    = is_load_q;
         we_d         = we_q;
         compressed_d = compressed_q;
         perf_d       = perf_q;
         waddr_d      = waddr_q;
         wdata_d      = wdata_q;
         if (capture) begin
            state_d      = FULL;
            is_load_d    = wb.instr_is_load_id_i;
            // A load's RF write comes from the LSU, never from the ID result.
            we_d         = wb.rf_we_id_i & ~wb.instr_is_load_id_i;
            compressed_d = wb.instr_is_compressed_id_i;
            perf_d       = wb.instr_perf_count_id_i;
            waddr_d      = wb.rf_waddr_id_i;
            wdata_d      = wb.rf_wdata_id_i;
         end else if (commit) begin
            state_d = EMPTY;
         end
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_q      <= EMPTY;
            is_load_q    <= 1'b0;
            we_q         <= 1'b0;
            compressed_q <= 1'b0;
            perf_q       <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
         end else begin
            state_q      <= state_d;
            is_load_q    <= is_load_d;
            we_q         <= we_d;
            compressed_q <= compressed_d;
            perf_q       <= perf_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
         end
      end

      assign rf_we_int = is_load_q ? (commit & wb.rf_we_lsu_i & ~wb.lsu_resp_err_i)
                                   : (valid_q & we_q);

      assign outstanding_load_wb = valid_q & is_load_q;
      assign rf_waddr_wb         = waddr_q;
      assign rf_we_wb            = rf_we_int;
      // Masked so RF data is zero whenever nothing is written.
      assign rf_wdata_wb         = {DataWidth{rf_we_int}} &
                                   (is_load_q ? wb.rf_wdata_lsu_i : wdata_q);
      assign rf_fwd_valid_wb     = valid_q & we_q & ~is_load_q;
      assign perf_instr_ret_wb   = commit & perf_q & ~(is_load_q & wb.lsu_resp_err_i);
      assign perf_instr_ret_compressed_wb = perf_instr_ret_wb & compressed_q;

`ifndef SYNTHESIS
      // A reset during load wait can leave a response already in flight in
      // the LSU; that first orphaned response is legal and simply ignored.
      logic orphan_ok_q, orphan_ok_d;

      always_comb begin
         orphan_ok_d = orphan_ok_q;
         if (rst_i) begin
            orphan_ok_d = orphan_ok_q | outstanding_load_wb;
         end else if (wb.lsu_resp_valid_i) begin
            orphan_ok_d = 1'b0;
         end
      end

      always_ff @(posedge clk_i) begin
         orphan_ok_q <= orphan_ok_d;
      end

      `define CVE2_WB_ASSERT(name, prop) \
         name: assert property (@(posedge clk_i) disable iff (rst_i) (prop)) \
            else $error("cve2_wb_stage: assertion name violated");

      `CVE2_WB_ASSERT(a_en_needs_ready, wb.en_wb_i |-> ready_wb)
      `CVE2_WB_ASSERT(a_resp_needs_load,
                      wb.lsu_resp_valid_i |-> (outstanding_load_wb | orphan_ok_q))
      `CVE2_WB_ASSERT(a_lsu_we_needs_resp, wb.rf_we_lsu_i |-> wb.lsu_resp_valid_i)

      `undef CVE2_WB_ASSERT
`endif

   end else begin : g_passthrough

      assign ready_wb            = 1'b1;
      assign outstanding_load_wb = 1'b0;
      assign rf_fwd_valid_wb     = 1'b0;
      assign rf_waddr_wb         = wb.rf_waddr_id_i;
      assign rf_wdata_wb         = ({DataWidth{wb.rf_we_id_i}}  & wb.rf_wdata_id_i) |
                                   ({DataWidth{wb.rf_we_lsu_i}} & wb.rf_wdata_lsu_i);
      assign rf_we_wb            = wb.rf_we_id_i | wb.rf_we_lsu_i;
      assign perf_instr_ret_wb   = wb.en_wb_i & wb.instr_perf_count_id_i &
                                   ~(wb.lsu_resp_valid_i & wb.lsu_resp_err_i);
      assign perf_instr_ret_compressed_wb = perf_instr_ret_wb &
                                            wb.instr_is_compressed_id_i;

`ifndef SYNTHESIS
      a_lsu_we_needs_resp: assert property (@(posedge clk_i) disable iff (rst_i)
                                            (wb.rf_we_lsu_i |-> wb.lsu_resp_valid_i))
         else $error("cve2_wb_stage: assertion a_lsu_we_needs_resp violated");
`endif

   end

   assign wb.ready_wb_o                     = ready_wb;
   assign wb.outstanding_load_wb_o          = outstanding_load_wb;
   assign wb.rf_waddr_wb_o                  = rf_waddr_wb;
   assign wb.rf_wdata_wb_o                  = rf_wdata_wb;
   assign wb.rf_we_wb_o                     = rf_we_wb;
   assign wb.rf_fwd_valid_wb_o              = rf_fwd_valid_wb;
   assign wb.perf_instr_ret_wb_o            = perf_instr_ret_wb;
   assign wb.perf_instr_ret_compressed_wb_o = perf_instr_ret_compressed_wb;

endmodule

// File: tb/tb_cve2_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_cve2_wb_stage
//
// Directed bench for cve2_wb_stage (WritebackStage=1). Inputs change on the
// falling edge; outputs are sampled 1ns later, so every row's expected values
// describe the stage state left by the previous rows plus that row's inputs.
// ----------------------------------------------------------------------------
module tb_cve2_wb_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cve2_wb_stage_if #(.DataWidth(DW), .AddrWidth(AW)) wb_if ();

   cve2_wb_stage #(
      .WritebackStage (1'b1),
      .DataWidth      (DW),
      .AddrWidth      (AW)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .wb    (wb_if)
   );

   // ---------------- vector table ----------------
   typedef struct packed {
      logic          en, ld, c, pc;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          we, lwe;
      logic [DW-1:0] ldat;
      logic          rv, err;
      logic          x_rdy, x_out, x_we;
      logic [AW-1:0] x_wa;
      logic [DW-1:0] x_wd;
      logic          x_fwd, x_p, x_pc;
   } vec_t;

   vec_t tab[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(int en, int ld, int c, int pc, int wa,
                               logic [DW-1:0] wd, int we, int lwe,
                               logic [DW-1:0] ldat, int rv, int err,
                               int x_rdy, int x_out, int x_we, int x_wa,
                               logic [DW-1:0] x_wd, int x_fwd, int x_p, int x_pc);
      vec_t v;
      v.en = 1'(en);  v.ld = 1'(ld);  v.c = 1'(c);  v.pc = 1'(pc);
      v.wa = AW'(wa); v.wd = wd;      v.we = 1'(we); v.lwe = 1'(lwe);
      v.ldat = ldat;  v.rv = 1'(rv);  v.err = 1'(err);
      v.x_rdy = 1'(x_rdy); v.x_out = 1'(x_out); v.x_we = 1'(x_we);
      v.x_wa = AW'(x_wa);  v.x_wd = x_wd;
      v.x_fwd = 1'(x_fwd); v.x_p = 1'(x_p); v.x_pc = 1'(x_pc);
      return v;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input vec_t v);
      wb_if.en_wb_i                  = v.en;
      wb_if.instr_is_load_id_i       = v.ld;
      wb_if.instr_is_compressed_id_i = v.c;
      wb_if.instr_perf_count_id_i    = v.pc;
      wb_if.rf_waddr_id_i            = v.wa;
      wb_if.rf_wdata_id_i            = v.wd;
      wb_if.rf_we_id_i               = v.we;
      wb_if.rf_we_lsu_i              = v.lwe;
      wb_if.rf_wdata_lsu_i           = v.ldat;
      wb_if.lsu_resp_valid_i         = v.rv;
      wb_if.lsu_resp_err_i           = v.err;
   endtask

   task automatic drive_idle();
      drive(mk(0,0,0,0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [DW-1:0] act,
                        input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input vec_t v);
      check({tag, ".ready"},  DW'(wb_if.ready_wb_o),                     DW'(v.x_rdy));
      check({tag, ".outst"},  DW'(wb_if.outstanding_load_wb_o),          DW'(v.x_out));
      check({tag, ".we"},     DW'(wb_if.rf_we_wb_o),                     DW'(v.x_we));
      check({tag, ".waddr"},  DW'(wb_if.rf_waddr_wb_o),                  DW'(v.x_wa));
      check({tag, ".wdata"},  wb_if.rf_wdata_wb_o,                       v.x_wd);
      check({tag, ".fwd"},    DW'(wb_if.rf_fwd_valid_wb_o),              DW'(v.x_fwd));
      check({tag, ".perf"},   DW'(wb_if.perf_instr_ret_wb_o),            DW'(v.x_p));
      check({tag, ".perf_c"}, DW'(wb_if.perf_instr_ret_compressed_wb_o), DW'(v.x_pc));
   endtask

   // Expected-only record for an empty, freshly reset stage.
   function automatic vec_t idle_exp(int wa);
      return mk(0,0,0,0,0,0,0, 0,0,0,0, 1,0,0,wa,0,0,0,0);
   endfunction

   // ---------------- test ----------------
   initial begin
      drive_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 check_outs("reset", idle_exp(0));
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1 check_outs($sformatf("idle%0d", i), idle_exp(0));
      end

      //            en ld c pc wa wd           we  lwe ldat        rv err  rdy out we wa wd           fwd p pc
      // single ALU op, result visible one cycle later, gone the cycle after
      tab.push_back(mk(1,0,1,1, 5,32'hDEADBEEF,1,  0,0,           0,0,   1,0,0, 0,0,            0,0,0));
      tab.push_back(mk(0,0,0,0, 0,0,           0,  0,0,           0,0,   1,0,1, 5,32'hDEADBEEF, 1,1,1));
      tab.push_back(mk(0,0,0,0, 0,0,           0,  0,0,           0,0,   1,0,0, 5,0,            0,0,0));
      // four back-to-back ALU ops
      tab.push_back(mk(1,0,0,1, 1,32'h11,      1,  0,0,           0,0,   1,0,0, 5,0,            0,0,0));
      tab.push_back(mk(1,0,0,1, 2,32'h22,      1,  0,0,           0,0,   1,0,1, 1,32'h11,       1,1,0));
      tab.push_back(mk(1,0,0,1, 3,32'h33,      1,  0,0,           0,0,   1,0,1, 2,32'h22,       1,1,0));
      tab.push_back(mk(1,0,0,1, 4,32'h44,      1,  0,0,           0,0,   1,0,1, 3,32'h33,       1,1,0));
      tab.push_back(mk(0,0,0,0, 0,0,           0,  0,0,           0,0,   1,0,1, 4,32'h44,       1,1,0));
      // op without RF write and without perf count: data must be masked
      tab.push_back(mk(1,0,1,0, 9,32'h99,      0,  0,0,           0,0,   1,0,0, 4,0,            0,0,0));
      tab.push_back(mk(0,0,0,0, 0,0,           0,  0,0,           0,0,   1,0,0, 9,0,            0,0,0));
      // load to x7 (ID we ignored), 3 wait cycles, response + new ALU op accepted
      tab.push_back(mk(1,1,0,1, 7,32'hFFFF,    1,  0,0,           0,0,   1,0,0, 9,0,            0,0,0));
      tab.push_back(mk(0,0,0,0, 0,0,           0,  0,32'hAAAA,    0,0,   0,1,0, 7,0,            0,0,0));
      tab.push_back(mk(0,0,0,0, 0,0,           0,  0,32'hAAAA,    0,0,   0,1,0, 7,0,            0,0,0));
      tab.push_back(mk(0,0,0,0, 0,0,           0,  0,32'hAAAA,    0,0,   0,1,0, 7,0,            0,0,0));
      tab.push_back(mk(1,0,1,1, 3,32'h5555,    1,  1,32'h1234,    1,0,   1,1,1, 7,32'h1234,     0,1,0));
      tab.push_back(mk(0,0,0,0, 0,0,           0,  0,0,           0,0,   1,0,1, 3,32'h5555,     1,1,1));
      // load with error response: retires, no write, no perf pulse
      tab.push_back(mk(1,1,1,1, 8,0,           0,  0,0,           0,0,   1,0,0, 3,0,            0,0,0));
      tab.push_back(mk(0,0,0,0, 0,0,           0,  1,32'hBAD,     1,1,   1,1,0, 8,0,            0,0,0));
      tab.push_back(mk(0,0,0,0, 0,0,           0,  0,0,           0,0,   1,0,0, 8,0,            0,0,0));

      foreach (tab[i]) begin
         @(negedge clk);
         drive(tab[i]);
         #1 check_outs($sformatf("row%0d", i), tab[i]);
      end

      // reset during load wait, then an orphaned LSU response
      @(negedge clk);
      drive(mk(1,1,0,1, 12,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0));
      @(negedge clk);
      drive_idle();
      #1 check_outs("ldwait", mk(0,0,0,0,0,0,0, 0,0,0,0, 0,1,0,12,0,0,0,0));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      drive(mk(0,0,0,0, 0,0,0, 1,32'h77,1,0, 0,0,0,0,0,0,0,0));
      #1 check_outs("stray", idle_exp(0));
      @(negedge clk);
      drive_idle();
      #1 check_outs("after_stray", idle_exp(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
